// File: rtl/mul_arb.sv
// Two-requester round-robin front end for a shared multi-cycle shift-add multiplier engine.
// One operation is in flight at a time; zero operands bypass the engine, and a stalled engine times out.
module mul_arb #(
    parameter int W       = 8,
    parameter int TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [2*W-1:0]   rsp_data,
    output logic             rsp_err,
    output logic             eng_start,
    output logic [W-1:0]     eng_a,
    output logic [W-1:0]     eng_b,
    input  logic             eng_done,
    input  logic [2*W-1:0]   eng_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [1:0]     state_q;
    logic [CW-1:0]  cnt_q;
    logic           last_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           id_q;
    logic           err_q;
    logic           byp_q;
    logic [2*W-1:0] data_q;

    logic           idle;
    logic           grant0;
    logic           grant1;
    logic           accept;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic           timeout_hit;
    logic           in_resp;
    logic           eng_act;

    // On a tie the requester that did not win last time is granted.
    assign idle        = (state_q == S_IDLE);
    assign grant0      = req0_valid & (~req1_valid | last_q);
    assign grant1      = req1_valid & (~req0_valid | ~last_q);
    assign req0_ready  = idle & grant0;
    assign req1_ready  = idle & grant1;
    assign accept      = req0_ready | req1_ready;
    assign sel_a       = grant1 ? req1_a : req0_a;
    assign sel_b       = grant1 ? req1_b : req0_b;
    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
            byp_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        a_q    <= sel_a;
                        b_q    <= sel_b;
                        id_q   <= grant1;
                        last_q <= grant1;
                        err_q  <= 1'b0;
                        data_q <= '0;
                        if (sel_a == '0 || sel_b == '0) begin
                            byp_q   <= 1'b1;
                            state_q <= S_RESP;
                        end else begin
                            byp_q   <= 1'b0;
                            state_q <= S_START;
                        end
                    end
                end
                S_START: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + CW'(1);
                    // A done arriving on the final wait cycle still wins over the timeout.
                    if (eng_done) begin
                        data_q  <= eng_o;
                        err_q   <= 1'b0;
                        state_q <= S_RESP;
                    end else if (timeout_hit) begin
                        data_q  <= '0;
                        err_q   <= 1'b1;
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Engine operands are only presented while the engine is actually in use.
    assign in_resp   = (state_q == S_RESP);
    assign eng_act   = (state_q == S_START) | (state_q == S_WAIT) | (in_resp & ~byp_q);
    assign eng_start = (state_q == S_START);
    assign eng_a     = eng_act ? a_q : '0;
    assign eng_b     = eng_act ? b_q : '0;
    assign rsp_valid = in_resp;
    assign rsp_id    = in_resp & id_q;
    assign rsp_data  = in_resp ? data_q : '0;
    assign rsp_err   = in_resp & err_q;

endmodule

// File: tb/tb_mul_arb.sv
// Bench for mul_arb: directed vector table, hand-written corner sequences and a randomized
// run against a transaction-level model of arbitration, latency and result.
module tb_mul_arb;

    localparam int W       = 8;
    localparam int TIMEOUT = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req0_valid = 1'b0, req1_valid = 1'b0;
    logic            req0_ready, req1_ready;
    logic [W-1:0]    req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic            rsp_valid, rsp_id, rsp_err;
    logic            rsp_ready = 1'b0;
    logic [2*W-1:0]  rsp_data;
    logic            eng_start, eng_done = 1'b0;
    logic [W-1:0]    eng_a, eng_b;
    logic [2*W-1:0]  eng_o = '0;

    int n_cmp = 0;
    int n_err = 0;
    logic m_last;

    mul_arb #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b),
        .eng_done(eng_done), .eng_o(eng_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       id;
        logic [7:0] a;
        logic [7:0] b;
        int         k;
        logic [15:0] d;
        logic       e;
        int         bp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_eng_start"}, 32'(eng_start), 0);
        chk({nm, "_eng_ab"}, 32'({eng_a, eng_b}), 0);
        chk({nm, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({nm, "_rsp_fields"}, 32'({rsp_id, rsp_err, rsp_data}), 0);
    endtask

    // Caller sets the request inputs at a negedge; this call checks the grant in that cycle
    // and follows the operation through to its response handshake.
    task automatic serve(input logic id, input logic [7:0] a, input logic [7:0] b, input int k,
                         input logic [15:0] exp_d, input logic exp_e, input bit keep,
                         input int bp, input string nm);
        bit   byp, seen, fin;
        int   t, hold, lat;
        logic [15:0] prod;
        byp  = (a == 0) || (b == 0);
        lat  = byp ? 1 : ((k >= 1 && k <= TIMEOUT) ? 2 + k : 2 + TIMEOUT);
        prod = 16'(a) * 16'(b);
        seen = 0; fin = 0; t = 0; hold = 0;
        rsp_ready = 1'b0;
        eng_done  = 1'b0;
        #1;
        chk({nm, "_grant"}, 32'({req1_ready, req0_ready}), id ? 32'd2 : 32'd1);
        while (!fin) begin
            @(negedge clk);
            t++;
            if (!keep) begin
                if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
            end
            eng_done = !byp && k >= 1 && t == 1 + k;
            eng_o    = eng_done ? prod : 16'($urandom);
            #1;
            chk({nm, "_eng_start"}, 32'(eng_start), 32'(t == 1 && !byp));
            if (t == 1 && !byp) chk({nm, "_eng_ab"}, 32'({eng_a, eng_b}), 32'({a, b}));
            chk({nm, "_busy_ready"}, 32'({req1_ready, req0_ready}), 0);
            if (rsp_valid) begin
                if (!seen) chk({nm, "_latency"}, 32'(t), 32'(lat));
                seen = 1;
                chk({nm, "_rsp"}, 32'({rsp_id, rsp_err, rsp_data}), 32'({id, exp_e, exp_d}));
                rsp_ready = (hold >= bp);
                hold++;
                if (rsp_ready) fin = 1;
            end else begin
                chk({nm, "_idle_data"}, 32'({rsp_id, rsp_err, rsp_data}), 0);
                if (t >= lat) chk({nm, "_rsp_valid"}, 32'(rsp_valid), 1);
            end
            if (!fin && t > lat + bp + 4) begin
                chk({nm, "_budget"}, 32'(t), 32'(lat));
                fin = 1;
            end
        end
        eng_done = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        eng_done = 1'b0;
        @(negedge clk);
        #1;
        chk_all_zero("reset");
        chk("reset_ready", 32'({req1_ready, req0_ready}), 0);
        rst_n = 1'b1;
        m_last = 1'b1;
    endtask

    initial begin
        vecs[0] = '{1'b0, 8'd12,  8'd13,  9,           16'h009C, 1'b0, 0};
        vecs[1] = '{1'b1, 8'd0,   8'd77,  4,           16'h0000, 1'b0, 0};
        vecs[2] = '{1'b0, 8'd255, 8'd255, 1,           16'hFE01, 1'b0, 0};
        vecs[3] = '{1'b1, 8'd3,   8'd5,   TIMEOUT,     16'h000F, 1'b0, 0};
        vecs[4] = '{1'b0, 8'd7,   8'd9,   0,           16'h0000, 1'b1, 0};
        vecs[5] = '{1'b1, 8'd200, 8'd0,   5,           16'h0000, 1'b0, 5};
        vecs[6] = '{1'b0, 8'd17,  8'd19,  3,           16'd323,  1'b0, 5};
        vecs[7] = '{1'b1, 8'd128, 8'd2,   TIMEOUT + 1, 16'h0000, 1'b1, 1};

        do_reset();

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (vecs[i].id) begin
                req1_valid = 1'b1; req1_a = vecs[i].a; req1_b = vecs[i].b;
            end else begin
                req0_valid = 1'b1; req0_a = vecs[i].a; req0_b = vecs[i].b;
            end
            serve(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].k, vecs[i].d, vecs[i].e, 0,
                  vecs[i].bp, $sformatf("vec%0d", i));
        end

        // Late engine done while idle must not produce anything.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            eng_done = 1'b1;
            eng_o = 16'hBEEF;
            #1;
            chk("late_done_rsp", 32'({rsp_valid, eng_start}), 0);
        end
        eng_done = 1'b0;

        // Tie after reset, both held valid: grants alternate starting with req0.
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 8'd255; req0_b = 8'd255;
        req1_valid = 1'b1; req1_a = 8'd3;   req1_b = 8'd5;
        serve(1'b0, 8'd255, 8'd255, 3, 16'hFE01, 1'b0, 1, 0, "tie0");
        @(negedge clk);
        serve(1'b1, 8'd3, 8'd5, 2, 16'h000F, 1'b0, 1, 0, "tie1");
        @(negedge clk);
        serve(1'b0, 8'd255, 8'd255, 1, 16'hFE01, 1'b0, 1, 2, "tie2");
        @(negedge clk);
        serve(1'b1, 8'd3, 8'd5, 6, 16'h000F, 1'b0, 0, 0, "tie3");
        @(negedge clk);
        req0_valid = 1'b0;

        // Reset in the middle of WAIT abandons the operation and restores the pointer.
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 8'd9; req0_b = 8'd9;
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("midwait_state", 32'({eng_a, eng_b}), 32'({8'd9, 8'd9}));
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk_all_zero("midwait_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            eng_done = (i == 1);
            eng_o = 16'h0051;
            #1;
            chk("midwait_no_rsp", 32'({rsp_valid, eng_start}), 0);
        end
        eng_done = 1'b0;
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 8'd4; req0_b = 8'd6;
        req1_valid = 1'b1; req1_a = 8'd2; req1_b = 8'd2;
        serve(1'b0, 8'd4, 8'd6, 2, 16'd24, 1'b0, 0, 0, "post_reset");
        @(negedge clk);
        req1_valid = 1'b0;

        // Randomized traffic against the transaction model.
        do_reset();
        for (int n = 0; n < 40; n++) begin
            int          pat, k, bp;
            logic [7:0]  a0, b0, a1, b1, a, b;
            logic        eid, ee;
            logic [15:0] ed;
            @(negedge clk);
            pat = $urandom_range(1, 3);
            a0 = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            b0 = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            a1 = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            b1 = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            k  = $urandom_range(0, TIMEOUT + 2);
            bp = $urandom_range(0, 3);
            req0_valid = pat[0]; req0_a = a0; req0_b = b0;
            req1_valid = pat[1]; req1_a = a1; req1_b = b1;
            eid = (pat == 3) ? ~m_last : (pat == 2);
            m_last = eid;
            a = eid ? a1 : a0;
            b = eid ? b1 : b0;
            if (a == 0 || b == 0) begin
                ed = 16'h0; ee = 1'b0;
            end else if (k >= 1 && k <= TIMEOUT) begin
                ed = 16'(a) * 16'(b); ee = 1'b0;
            end else begin
                ed = 16'h0; ee = 1'b1;
            end
            serve(eid, a, b, k, ed, ee, 0, bp, $sformatf("rnd%0d", n));
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
